// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// state encodings, datapath width and the divide-by-zero quotient value.
package muldiv_pkg;

   localparam int WIDTH = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2
   } state_t;

   // MULT and DIV are the signed flavours; they run on magnitudes.
   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   // Magnitude of a two's-complement value when en is set, raw bits otherwise.
   function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic en);
      return (en && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_hilo_unit_signfix.sv
// Final correction of the unsigned iteration result: two's-complement fixup
// for MULT/DIV and the divide-by-zero override, producing the HI/LO values.
module muldiv_signfix
   import muldiv_pkg::*;
(
   input  logic [2*WIDTH-1:0] i_raw,
   input  logic [1:0]         i_op,
   input  logic               i_sign_a,
   input  logic               i_sign_b,
   input  logic               i_div0,
   input  logic [WIDTH-1:0]   i_a_raw,
   output logic [WIDTH-1:0]   o_hi,
   output logic [WIDTH-1:0]   o_lo
);

   logic [2*WIDTH-1:0] w_neg_prod;
   logic [WIDTH-1:0]   w_neg_quot;
   logic [WIDTH-1:0]   w_neg_rem;

   assign w_neg_prod = ~i_raw + 1'b1;
   assign w_neg_quot = ~i_raw[WIDTH-1:0] + 1'b1;
   assign w_neg_rem  = ~i_raw[2*WIDTH-1:WIDTH] + 1'b1;

   // Select the corrected HI/LO pair for the finished operation.
   always_comb begin
      o_hi = i_raw[2*WIDTH-1:WIDTH];
      o_lo = i_raw[WIDTH-1:0];
      case (i_op)
         OP_MULT: begin
            if (i_sign_a ^ i_sign_b) begin
               o_hi = w_neg_prod[2*WIDTH-1:WIDTH];
               o_lo = w_neg_prod[WIDTH-1:0];
            end
         end
         OP_DIV: begin
            // Quotient sign follows the operand signs, remainder follows the dividend.
            if (i_sign_a ^ i_sign_b) o_lo = w_neg_quot;
            if (i_sign_a)            o_hi = w_neg_rem;
         end
         OP_MULTU, OP_DIVU: begin
         end
         default: begin
         end
      endcase
      // Divide by zero reports all-ones quotient and the untouched dividend bits.
      if (i_op[1] && i_div0) begin
         o_lo = DIV0_LO;
         o_hi = i_a_raw;
      end
   end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit owning HI/LO. One operand bit per cycle for
// 32 cycles in CALC, one SIGN cycle for fixup, then HI/LO are written.
// Handshake: start is a level sampled only while busy=0; an accepted start
// holds busy high for 33 cycles, after which done pulses for exactly one cycle
// with HI/LO already updated; a start in that done cycle is accepted.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [1:0]       dbg_state
);

   import muldiv_pkg::*;

   state_t           r_state;
   logic [4:0]       r_cnt;
   logic [1:0]       r_op;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_b_zero;
   logic [WIDTH-1:0] r_a_raw;
   logic [WIDTH-1:0] r_mag_a;
   logic [WIDTH-1:0] r_mag_b;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;

   logic             w_is_div;
   logic             w_sgn;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH-1:0] w_div_diff;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_nxt_hi;
   logic [WIDTH-1:0] w_nxt_lo;
   logic [WIDTH-1:0] w_fix_hi;
   logic [WIDTH-1:0] w_fix_lo;

   // Multiply: accumulator {acc_hi, acc_lo} shifts right, multiplier bits leave
   // from acc_lo[0] while product bits enter at the top.
   // Divide: acc_lo shifts dividend bits out and quotient bits in; acc_hi is
   // the partial remainder, restored when the trial subtraction would borrow.
   assign w_is_div    = r_op[1];
   assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_a} : '0);
   assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
   assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mag_b;
   assign w_nxt_hi    = w_is_div ? (w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0])
                                 : w_mul_sum[WIDTH:1];
   assign w_nxt_lo    = w_is_div ? {r_acc_lo[WIDTH-2:0], w_div_ge}
                                 : {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
   assign w_sgn       = is_signed_op(op);

   muldiv_signfix u_signfix (
      .i_raw    ({r_acc_hi, r_acc_lo}),
      .i_op     (r_op),
      .i_sign_a (r_sign_a),
      .i_sign_b (r_sign_b),
      .i_div0   (r_b_zero),
      .i_a_raw  (r_a_raw),
      .o_hi     (w_fix_hi),
      .o_lo     (w_fix_lo)
   );

   // Control FSM, operand capture, iteration datapath and HI/LO ownership.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_b_zero <= 1'b0;
         r_a_raw  <= '0;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !flush) begin
                  // start wins over a simultaneous MTHI/MTLO, which is dropped.
                  r_state  <= ST_CALC;
                  r_cnt    <= 5'(ITER - 1);
                  r_op     <= op;
                  r_sign_a <= w_sgn & A[WIDTH-1];
                  r_sign_b <= w_sgn & B[WIDTH-1];
                  r_b_zero <= (B == '0);
                  r_a_raw  <= A;
                  r_mag_a  <= mag_of(A, w_sgn);
                  r_mag_b  <= mag_of(B, w_sgn);
                  r_acc_hi <= '0;
                  r_acc_lo <= op[1] ? mag_of(A, w_sgn) : mag_of(B, w_sgn);
               end else begin
                  if (mthi) r_hi <= wdata;
                  if (mtlo) r_lo <= wdata;
               end
            end
            ST_CALC: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_acc_hi <= w_nxt_hi;
                  r_acc_lo <= w_nxt_lo;
                  if (r_cnt == 5'd0) r_state <= ST_SIGN;
                  else               r_cnt   <= r_cnt - 5'd1;
               end
            end
            ST_SIGN: begin
               r_state <= ST_IDLE;
               if (!flush) begin
                  r_hi   <= w_fix_hi;
                  r_lo   <= w_fix_lo;
                  r_done <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign HI        = r_hi;
   assign LO        = r_lo;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed cases with literal results plus a long
// randomized phase, all compared cycle by cycle against an arithmetic model.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic start;
  logic [1:0] op;
  logic [31:0] a, b, wdata;
  logic mthi, mtlo, flush;
  logic busy, done;
  logic [31:0] hi, lo;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .HI(hi), .LO(lo), .dbg_state(dbg_state)
  );

  // ---------------- counters / check helper ----------------
  int n_vec = 0;
  int n_fail = 0;
  bit en_cmp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Result of an operation from plain arithmetic on the operand values.
  function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      OP_MULTU: p = {32'd0, x} * {32'd0, y};
      OP_MULT:  begin q = sx * sy; p = q; end
      OP_DIVU:  if (y == 0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
      default:  if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
    endcase
    return p;
  endfunction

  bit m_busy, m_done;
  int m_left;
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  logic [63:0] m_tmp;

  // Model: an accepted op stays busy for 33 edges, then commits its result.
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_left = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start && !flush) begin
          m_tmp = model_result(op, a, b);
          m_res_hi = m_tmp[63:32];
          m_res_lo = m_tmp[31:0];
          m_busy = 1; m_left = 33;
        end else begin
          if (mthi) m_hi = wdata;
          if (mtlo) m_lo = wdata;
        end
      end else if (flush) begin
        m_busy = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = m_res_hi; m_lo = m_res_lo;
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (en_cmp) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("HI", hi, m_hi);
      chk("LO", lo, m_lo);
      chk("idle_state", {31'd0, dbg_state == ST_IDLE}, {31'd0, !m_busy});
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input string nm, output int k);
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL %s: done not seen within 60 cycles", nm);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int k;
    reset = 1; start = 0; op = 0; a = 0; b = 0; wdata = 0;
    mthi = 0; mtlo = 0; flush = 0;
    repeat (2) @(negedge clk);
    en_cmp = 1;
    chk("rst_HI", hi, 32'h0);
    chk("rst_LO", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 0;
    @(negedge clk);

    // MULTU all-ones squared, with latency
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_lat", k);
    chk("multu_latency", 32'(k), 32'd33);
    chk("multu_HI", hi, 32'hFFFF_FFFE);
    chk("multu_LO", lo, 32'h0000_0001);
    @(negedge clk);

    // MULT -3 * 7
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult", k);
    chk("mult_HI", hi, 32'hFFFF_FFFF);
    chk("mult_LO", lo, 32'hFFFF_FFEB);

    // DIV -7 / 2, then DIVU 7 / 2 started in the done cycle
    @(negedge clk);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", k);
    chk("div_LO", lo, 32'hFFFF_FFFD);
    chk("div_HI", hi, 32'hFFFF_FFFF);
    launch(OP_DIVU, 32'd7, 32'd2);
    wait_done("divu_b2b", k);
    chk("b2b_latency", 32'(k), 32'd33);
    chk("divu_LO", lo, 32'd3);
    chk("divu_HI", hi, 32'd1);

    // signed overflow and divide by zero
    @(negedge clk);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", k);
    chk("ovf_LO", lo, 32'h8000_0000);
    chk("ovf_HI", hi, 32'h0);
    @(negedge clk);
    launch(OP_DIVU, 32'h1234_5678, 32'h0);
    wait_done("div0", k);
    chk("div0_LO", lo, 32'hFFFF_FFFF);
    chk("div0_HI", hi, 32'h1234_5678);

    // start and mthi while busy are ignored; then mtlo in idle
    @(negedge clk);
    launch(OP_MULTU, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    start = 1; op = OP_DIVU; a = 32'd100; b = 32'd3; mthi = 1; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 0; mthi = 0;
    wait_done("busy_ignore", k);
    chk("ign_HI", hi, 32'd0);
    chk("ign_LO", lo, 32'd30);
    @(negedge clk);
    mtlo = 1; wdata = 32'h0000_ABCD;
    @(negedge clk);
    mtlo = 0;
    chk("mtlo_LO", lo, 32'h0000_ABCD);
    chk("mtlo_HI", hi, 32'd0);

    // preload, then flush mid-op
    mthi = 1; wdata = 32'd1;
    @(negedge clk);
    mthi = 0; mtlo = 1; wdata = 32'd2;
    @(negedge clk);
    mtlo = 0;
    chk("pre_HI", hi, 32'd1);
    chk("pre_LO", lo, 32'd2);
    launch(OP_MULT, 32'hFFFF_0001, 32'h0000_7777);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_HI", hi, 32'd1);
    chk("flush_LO", lo, 32'd2);
    repeat (40) @(negedge clk);

    // start with flush in idle: start ignored
    start = 1; flush = 1; op = OP_MULTU; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 0; flush = 0;
    chk("sf_busy", {31'd0, busy}, 32'd0);

    // reset mid-op
    launch(OP_MULT, 32'h0000_1234, 32'hFFFF_FF00);
    repeat (19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rmid_HI", hi, 32'd0);
    chk("rmid_LO", lo, 32'd0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick_val();
      b     = pick_val();
      mthi  = ($urandom_range(0, 9) == 0);
      mtlo  = ($urandom_range(0, 9) == 0);
      wdata = $urandom;
      flush = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    start = 0; mthi = 0; mtlo = 0; flush = 0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
